// File: rtl/fpu_norm_shift.sv
// fpu_norm_shift: two-stage pipelined normalizer for the FPU datapath.
// Counts the leading zeros of an unnormalized magnitude, left-shifts it so
// its MSB is set, and adjusts the signed exponent by the shift amount.
// Optional build macro FPU_NORM_DENORM_EN: clamp the shift so the exponent
// does not go below EMIN. The result may then stay denormal.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           synchronous pipeline kill (valid bits only)
//   in_valid/ready  input handshake; in_ready is combinational on out_ready
//   in_mant, in_exp unnormalized magnitude and its signed exponent
//   out_valid/ready output handshake
//   out_mant        normalized magnitude
//   out_exp         adjusted signed exponent
//   out_lzc         leading-zero count of the input (WIDTH for zero)
//   out_zero        input magnitude was zero
//   out_uflow       exponent below EMIN, or result left denormal

// 8-bit leading-zero counter leaf; cnt_o = 8 when d_i is zero.
module lzc_8 (
  input  logic [7:0] d_i,
  output logic [3:0] cnt_o,
  output logic       any_o
);
  // The highest set bit is visited last, so it determines the count.
  always_comb begin
    cnt_o = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (d_i[i]) cnt_o = 4'(7 - i);
    end
    any_o = |d_i;
  end
endmodule

module fpu_norm_shift #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned EXP_W = 10,
  parameter int          EMIN  = -126
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_mant,
  input  logic [EXP_W-1:0]           in_exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_mant,
  output logic [EXP_W-1:0]           out_exp,
  output logic [$clog2(WIDTH):0]     out_lzc,
  output logic                       out_zero,
  output logic                       out_uflow
);

  localparam int unsigned LZW   = $clog2(WIDTH) + 1;
  localparam int unsigned NLEAF = WIDTH / 8;
  localparam int unsigned NLVL  = $clog2(NLEAF);
  localparam int unsigned XW    = EXP_W + 1;
  localparam logic signed [XW-1:0] EMIN_X = XW'(EMIN);

  // ---------------------------------------------------------------
  // LZC tree: lzc_8 leaves, leaf 0 holds the most significant byte
  // ---------------------------------------------------------------
  logic [3:0]     leaf_cnt [NLEAF];
  logic           leaf_any [NLEAF];
  logic [LZW-1:0] node_cnt [NLEAF];
  logic           node_any [NLEAF];
  logic [LZW-1:0] lzc_c;

  for (genvar g = 0; g < NLEAF; g++) begin : g_leaf
    lzc_8 u_lzc (
      .d_i   (in_mant[WIDTH-1-8*g -: 8]),
      .cnt_o (leaf_cnt[g]),
      .any_o (leaf_any[g])
    );
  end

  // Pairwise merge per level: the upper half's count wins when it holds a
  // set bit, otherwise the upper half is all zeros and adds its full size.
  always_comb begin
    for (int unsigned i = 0; i < NLEAF; i++) begin
      node_cnt[i] = LZW'(leaf_cnt[i]);
      node_any[i] = leaf_any[i];
    end
    for (int unsigned l = 0; l < NLVL; l++) begin
      for (int unsigned p = 0; p < (NLEAF >> (l + 1)); p++) begin
        if (!node_any[p << (l + 1)]) begin
          node_cnt[p << (l + 1)] = LZW'(32'd8 << l) + node_cnt[(p << (l + 1)) + (1 << l)];
        end
        node_any[p << (l + 1)] = node_any[p << (l + 1)] | node_any[(p << (l + 1)) + (1 << l)];
      end
    end
    lzc_c = node_cnt[0];
  end

  // ---------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_advance;

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;

  // ---------------------------------------------------------------
  // Stage S1: register input and its LZC
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] s1_mant_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [LZW-1:0]   s1_lzc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lzc_q   <= '0;
    end else begin
      if (flush)         s1_valid_q <= 1'b0;
      else if (in_ready) s1_valid_q <= in_valid;
      if (in_valid && in_ready) begin
        s1_mant_q <= in_mant;
        s1_exp_q  <= in_exp;
        s1_lzc_q  <= lzc_c;
      end
    end
  end

  // ---------------------------------------------------------------
  // S2 input cone: shift amount, shifter, exponent adjust, flags
  // ---------------------------------------------------------------
  logic signed [XW-1:0] exp_x;
  logic signed [XW-1:0] exp_res;
  logic [LZW-1:0]       shift_c;
  logic [WIDTH-1:0]     mant_sh;
  logic [WIDTH-1:0]     mant_d;
  logic [EXP_W-1:0]     exp_d;
  logic                 zero_d;
  logic                 uflow_d;
`ifdef FPU_NORM_DENORM_EN
  logic signed [XW:0]   head_c;
  logic signed [XW:0]   lzc_x;
`endif

  assign exp_x = XW'($signed(s1_exp_q));

`ifdef FPU_NORM_DENORM_EN
  // Headroom above EMIN bounds the shift so the exponent never passes EMIN.
  assign head_c = (XW + 1)'(exp_x) - (XW + 1)'(EMIN);
  assign lzc_x  = $signed((XW + 1)'(s1_lzc_q));

  always_comb begin
    shift_c = s1_lzc_q;
    if (exp_x < EMIN_X)      shift_c = '0;
    else if (head_c < lzc_x) shift_c = head_c[LZW-1:0];
  end
`else
  assign shift_c = s1_lzc_q;
`endif

  assign mant_sh = s1_mant_q << shift_c;
  assign exp_res = exp_x - $signed(XW'(shift_c));

  always_comb begin
    zero_d  = (s1_mant_q == '0);
    mant_d  = mant_sh;
    exp_d   = exp_res[EXP_W-1:0];
`ifdef FPU_NORM_DENORM_EN
    uflow_d = (exp_res < EMIN_X) || !mant_sh[WIDTH-1] || (exp_x < EMIN_X);
`else
    uflow_d = (exp_res < EMIN_X);
`endif
    if (zero_d) begin
      mant_d  = '0;
      exp_d   = '0;
      uflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // Stage S2: output registers, held while stalled
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] out_mant_q;
  logic [EXP_W-1:0] out_exp_q;
  logic [LZW-1:0]   out_lzc_q;
  logic             out_zero_q;
  logic             out_uflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_lzc_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      if (flush)           s2_valid_q <= 1'b0;
      else if (s1_advance) s2_valid_q <= s1_valid_q;
      if (s1_advance && s1_valid_q) begin
        out_mant_q  <= mant_d;
        out_exp_q   <= exp_d;
        out_lzc_q   <= s1_lzc_q;
        out_zero_q  <= zero_d;
        out_uflow_q <= uflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_lzc   = out_lzc_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

endmodule
